regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port integer register file for the single-cycle RISC-V core
//   and its successors. It provides 2 combinational read ports and 2 write ports with
//   fixed priority, plus optional same-cycle write-to-read bypass and an optional
//   hard-wired zero register. A soft-clear sequencer zeroes the array one entry per
//   cycle without asserting reset; the core stalls on busy. Sits between decode
//   (read addresses) and writeback (write ports).
// PARAMETERS
//   XLEN      32  data width in bits
//   NREGS     32  number of registers; power of two, >= 2
//   AW        $clog2(NREGS)  address width, derived, never overridden
//   ZERO_REG  1   1: entry 0 reads 0 and ignores writes; 0: entry 0 is ordinary
//   BYPASS    1   1: a read of an address being written this cycle returns the new data
// PORTS
//   clk        in   1     rising-edge clock
//   reset_n    in   1     asynchronous active-low reset
//   rs1_addr   in   AW    read port 1 address
//   rs2_addr   in   AW    read port 2 address
//   rs1_data   out  XLEN  read port 1 data
//   rs2_data   out  XLEN  read port 2 data
//   wa0        in   AW    write port 0 address
//   wd0        in   XLEN  write port 0 data
//   we0        in   1     write port 0 enable
//   wa1        in   AW    write port 1 address (priority port)
//   wd1        in   XLEN  write port 1 data
//   we1        in   1     write port 1 enable
//   clr_req    in   1     soft-clear request, sampled in IDLE only
//   busy       out  1     high while the clear sweep runs
//   clr_done   out  1     one-cycle pulse in the cycle after the last entry is cleared
// BEHAVIOUR
//   - Reset (reset_n=0, asynchronous): all entries=0, state=IDLE, ptr=0, busy=0, clr_done=0.
//   - Writes commit on the rising edge of clk when we=1 and state=IDLE.
//   - Same-address dual write: port 1 wins; port 0 is discarded entirely.
//   - ZERO_REG=1: writes to address 0 are dropped; reads of address 0 return 0 regardless of BYPASS.
//   - Reads are combinational (0-cycle latency), read-after-write latency is 1 cycle.
//     With BYPASS=1 it is 0 cycles: a read address matching an enabled, accepted write
//     returns that write's data, with port 1 taking priority over port 0.
//   - FSM IDLE -> CLEAR on clr_req=1 (busy rises next cycle, ptr=0). In CLEAR:
//     entry[ptr]<=0 and ptr++ each cycle. After ptr=NREGS-1 is cleared: -> IDLE,
//     busy=0 and clr_done=1 for exactly that one cycle. The sweep takes NREGS cycles.
//   - In CLEAR: we0/we1 are ignored (writes dropped, no bypass) and rs1_data/rs2_data=0.
//   - clr_req during CLEAR is ignored and does not restart the sweep. clr_req in the same
//     cycle as writes in IDLE: the writes commit and the sweep then overwrites them.
//   - Reset asserted mid-sweep: immediate IDLE with all entries 0, and no clr_done pulse.
//   - ptr is AW bits wide. The end test is ptr==NREGS-1, never ptr overflow.
// TESTING
//   1 reset_n low, then high; read all addresses -> every rs*_data=0, busy=0.
//   2 we1=1 wa1=5 wd1=32'hDEADBEEF; next cycle rs1_addr=5 -> 32'hDEADBEEF; with
//     BYPASS=1 the same-cycle rs2_addr=5 -> 32'hDEADBEEF; with BYPASS=0 -> old value 0.
//   3 we0=we1=1, wa0=wa1=7, wd0=32'h1, wd1=32'h2 -> reg7 reads 32'h2 (bypass and stored).
//   4 ZERO_REG=1: we0=1 wa0=0 wd0=32'hFFFFFFFF -> rs1_addr=0 reads 0, same cycle and after.
//   5 fill regs 1..31 with their index; pulse clr_req -> busy high for exactly 32 cycles,
//     writes during the sweep are dropped, clr_done pulses once, then all reads=0.
//   6 start a clear, drop reset_n low at sweep cycle 10 -> busy=0 immediately, no
//     clr_done, all reads=0; a write after release succeeds.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: 2 combinational reads, 2 prioritised writes,
// optional write-to-read bypass, optional hard-wired zero entry and soft-clear sweep.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),  // derived from NREGS; leave at default
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we0,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic            we1,
    input  logic            clr_req,
    output logic            busy,
    output logic            clr_done
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic            r_clr_done;
    logic [XLEN-1:0] r_mem [NREGS];

    logic w_idle;
    logic w_last;
    logic w_wr0;
    logic w_wr1;

    assign w_idle = (r_state == S_IDLE);
    assign w_last = (r_state == S_CLEAR) && (r_ptr == AW'(NREGS - 1));

    // Port 0 yields completely to port 1 on an address collision.
    assign w_wr1 = w_idle && we1 && !(ZERO_REG && (wa1 == '0));
    assign w_wr0 = w_idle && we0 && !(ZERO_REG && (wa0 == '0)) && !(we1 && (wa1 == wa0));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_done <= w_last;
            if (r_state == S_CLEAR) r_ptr <= r_ptr + 1'b1;
            else                    r_ptr <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if ((r_state == S_CLEAR) && (r_ptr == AW'(i))) r_mem[i] <= '0;
                else if (w_wr1 && (wa1 == AW'(i)))             r_mem[i] <= wd1;
                else if (w_wr0 && (wa0 == AW'(i)))             r_mem[i] <= wd0;
            end
        end
    end

    // Reads are forced to zero during the sweep and for entry 0 when it is hard-wired.
    function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = r_mem[a];
        if (BYPASS && w_wr0 && (wa0 == a)) v = wd0;
        if (BYPASS && w_wr1 && (wa1 == a)) v = wd1;
        if (!w_idle || (ZERO_REG && (a == '0))) v = '0;
        return v;
    endfunction

    assign rs1_data = f_read(rs1_addr);
    assign rs2_data = f_read(rs2_addr);
    assign busy     = (r_state == S_CLEAR);
    assign clr_done = r_clr_done;

endmodule
